// File: rtl/oam_dma_if.sv
// Signal bundle between the CPU core, the oam_dma bus stage, the system bus and OAM.
// The slave modport is the oam_dma view; master is the surrounding system's view.
interface oam_dma_if;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        bus_rd_en;
    logic        bus_wr_en;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    modport slave (
        input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, bus_rdata,
        output cpu_rdata, bus_rd_en, bus_wr_en, bus_addr, bus_wdata,
        output oam_we, oam_addr, oam_wdata, dma_active
    );

    modport master (
        output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, bus_rdata,
        input  cpu_rdata, bus_rd_en, bus_wr_en, bus_addr, bus_wdata,
        input  oam_we, oam_addr, oam_wdata, dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// CPU-to-system-bus stage owning the 0xFF46 OAM DMA source register and the copy engine.
// Optional OAM_DMA_BUS_CONFLICT_EN: locked-out CPU reads during a copy see the DMA's bus data.
//
// state  | meaning
// IDLE   | no copy running, CPU accesses pass straight through
// DELAY  | source written, waiting START_DELAY cycles, CPU already locked out
// ACTIVE | copying one byte per cycle unless the CPU touches HRAM
module oam_dma #(
    parameter int OAM_LEN     = 160,
    parameter int START_DELAY = 1
) (
    input logic      clk,
    input logic      rst,
    oam_dma_if.slave dif
);
    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [7:0]       LAST_IDX = 8'(OAM_LEN - 1);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(START_DELAY - 1);
    localparam logic [15:0]      REG_ADDR = 16'hFF46;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       src_q, src_d;
    logic [7:0]       idx_q, idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;

    logic       cpu_wr;
    logic       cpu_rd;
    logic       cpu_acc;
    logic       hit_reg;
    logic       hit_hram;
    logic       reg_wr;
    logic       fwd;
    logic       dma_go;
    logic [7:0] eff_src;

    // A simultaneous read and write is treated as a write only.
    assign cpu_wr   = dif.cpu_wr_en;
    assign cpu_rd   = dif.cpu_rd_en & ~dif.cpu_wr_en;
    assign cpu_acc  = cpu_wr | cpu_rd;
    assign hit_reg  = (dif.cpu_addr == REG_ADDR);
    assign hit_hram = (dif.cpu_addr >= 16'hFF80) && (dif.cpu_addr != 16'hFFFF);
    assign reg_wr   = cpu_wr & hit_reg;
    assign fwd      = cpu_acc & ~hit_reg & ((state_q == S_IDLE) | hit_hram);
    assign dma_go   = (state_q == S_ACTIVE) & ~(cpu_acc & hit_hram);
    // Sources at 0xE0 and above fold onto work RAM, as echo RAM does.
    assign eff_src  = (src_q < 8'hE0) ? src_q : (src_q & 8'hDF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= 8'hFF;
            idx_q   <= 8'h00;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        if (reg_wr) begin
            // A new source always restarts from index 0, even mid-copy.
            src_d   = dif.cpu_wdata;
            state_d = S_DELAY;
            dly_d   = DLY_INIT;
            idx_d   = 8'h00;
        end else begin
            unique case (state_q)
                S_DELAY: begin
                    if (dly_q == '0) begin
                        state_d = S_ACTIVE;
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (dma_go) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            idx_d   = 8'h00;
                        end else begin
                            idx_d = idx_q + 8'h01;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        dif.bus_rd_en  = 1'b0;
        dif.bus_wr_en  = 1'b0;
        dif.bus_addr   = 16'h0000;
        dif.bus_wdata  = 8'h00;
        dif.oam_we     = 1'b0;
        dif.oam_wdata  = 8'h00;
        dif.oam_addr   = idx_q;
        dif.dma_active = (state_q != S_IDLE);
        dif.cpu_rdata  = 8'hFF;

        if (fwd) begin
            dif.bus_rd_en = cpu_rd;
            dif.bus_wr_en = cpu_wr;
            dif.bus_addr  = dif.cpu_addr;
            dif.bus_wdata = cpu_wr ? dif.cpu_wdata : 8'h00;
        end else if (dma_go) begin
            dif.bus_rd_en = 1'b1;
            dif.bus_addr  = {eff_src, idx_q};
            dif.oam_we    = 1'b1;
            dif.oam_wdata = dif.bus_rdata;
        end

        if (hit_reg) begin
            dif.cpu_rdata = src_q;
        end else if ((state_q == S_IDLE) || hit_hram) begin
            dif.cpu_rdata = dif.bus_rdata;
        end else begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
            dif.cpu_rdata = (state_q == S_ACTIVE) ? dif.bus_rdata : 8'hFF;
`else
            dif.cpu_rdata = 8'hFF;
`endif
        end
    end
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a cycle-level behavioural model checks every output each cycle,
// and hand-computed literals pin the model at the interesting points.
module tb_oam_dma;
    localparam int OAM_LEN     = 160;
    localparam int START_DELAY = 1;
`ifdef OAM_DMA_BUS_CONFLICT_EN
    localparam bit         CONFLICT = 1'b1;
    localparam logic [7:0] LOCK_RD  = 8'h01;
`else
    localparam bit         CONFLICT = 1'b0;
    localparam logic [7:0] LOCK_RD  = 8'hFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oam_dma_if dif();
    // Memory model: every byte holds the low byte of its own address.
    assign dif.bus_rdata = dif.bus_addr[7:0];

    oam_dma #(.OAM_LEN(OAM_LEN), .START_DELAY(START_DELAY)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit         m_valid = 1'b0;
    bit         m_busy;
    int         m_wait;
    int         m_idx;
    logic [7:0] m_src;

    logic        e_reg, e_hram, e_wr, e_rd, e_fwd, e_copy;
    logic [15:0] e_bus_addr;
    logic [7:0]  e_rdata;

    function automatic logic [7:0] echo_map(input logic [7:0] s);
        return (s < 8'hE0) ? s : (s & 8'hDF);
    endfunction

    always_comb begin
        e_reg      = (dif.cpu_addr == 16'hFF46);
        e_hram     = (dif.cpu_addr >= 16'hFF80) && (dif.cpu_addr <= 16'hFFFE);
        e_wr       = dif.cpu_wr_en;
        e_rd       = dif.cpu_rd_en && !dif.cpu_wr_en;
        e_fwd      = (e_wr || e_rd) && !e_reg && (!m_busy || e_hram);
        e_copy     = m_busy && (m_wait == 0) && !(e_hram && (e_wr || e_rd));
        e_bus_addr = 16'h0000;
        if (e_fwd) e_bus_addr = dif.cpu_addr;
        else if (e_copy) e_bus_addr = {echo_map(m_src), m_idx[7:0]};
        e_rdata = 8'hFF;
        if (e_reg) e_rdata = m_src;
        else if (e_fwd) e_rdata = dif.cpu_addr[7:0];
        else if (CONFLICT && e_copy) e_rdata = e_bus_addr[7:0];
    end

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_wait  <= 0;
            m_idx   <= 0;
            m_src   <= 8'hFF;
        end else if (dif.cpu_wr_en && dif.cpu_addr == 16'hFF46) begin
            m_src  <= dif.cpu_wdata;
            m_busy <= 1'b1;
            m_wait <= START_DELAY;
            m_idx  <= 0;
        end else if (m_busy) begin
            if (m_wait > 0) m_wait <= m_wait - 1;
            else if (e_copy) begin
                if (m_idx == OAM_LEN - 1) begin
                    m_busy <= 1'b0;
                    m_idx  <= 0;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    // Observers: OAM image, pulse counts, last DMA source address
    logic [7:0]  oam_mem [OAM_LEN];
    int          we_cnt = 0;
    int          act_cnt = 0;
    logic [15:0] last_dma = 16'h0000;
    always @(negedge clk) begin
        if (!rst && dif.oam_we) begin
            oam_mem[dif.oam_addr] <= dif.oam_wdata;
            we_cnt   <= we_cnt + 1;
            last_dma <= dif.bus_addr;
        end
        if (!rst && dif.dma_active) act_cnt <= act_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (!m_valid) return;
        chk("m_bus_rd_en",  32'(dif.bus_rd_en),  32'((e_fwd && e_rd) || e_copy));
        chk("m_bus_wr_en",  32'(dif.bus_wr_en),  32'(e_fwd && e_wr));
        chk("m_bus_addr",   32'(dif.bus_addr),   32'(e_bus_addr));
        chk("m_bus_wdata",  32'(dif.bus_wdata),  32'((e_fwd && e_wr) ? dif.cpu_wdata : 8'h00));
        chk("m_oam_we",     32'(dif.oam_we),     32'(e_copy));
        chk("m_oam_addr",   32'(dif.oam_addr),   32'(m_idx[7:0]));
        chk("m_oam_wdata",  32'(dif.oam_wdata),  32'(e_copy ? e_bus_addr[7:0] : 8'h00));
        chk("m_dma_active", 32'(dif.dma_active), 32'(m_busy));
        if (e_rd) chk("m_cpu_rdata", 32'(dif.cpu_rdata), 32'(e_rdata));
    endtask

    // Defines one clock cycle of CPU inputs, then checks that cycle against the model.
    task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [7:0] d, input logic r = 1'b0);
        @(posedge clk);
        #1;
        rst           = r;
        dif.cpu_rd_en = rd;
        dif.cpu_wr_en = wr;
        dif.cpu_addr  = a;
        dif.cpu_wdata = d;
        #1;
        compare_model();
    endtask

    task automatic run_until_idle(input int budget);
        for (int k = 0; k < budget && dif.dma_active; k++) drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("dma_done", 32'(dif.dma_active), 32'd0);
    endtask

    task automatic run_to_idx(input int target, input string name);
        for (int k = 0; k < 400 && !(dif.oam_we && dif.oam_addr == 8'(target)); k++)
            drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk(name, 32'(dif.oam_addr), 32'(target));
    endtask

    int we0, a0, bad;

    initial begin
        dif.cpu_rd_en = 1'b0;
        dif.cpu_wr_en = 1'b0;
        dif.cpu_addr  = 16'h0000;
        dif.cpu_wdata = 8'h00;

        // Reset state
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("rst_dma_active", 32'(dif.dma_active), 32'd0);
        chk("rst_oam_we",     32'(dif.oam_we),     32'd0);
        chk("rst_oam_addr",   32'(dif.oam_addr),   32'd0);
        chk("rst_oam_wdata",  32'(dif.oam_wdata),  32'd0);
        chk("rst_bus_addr",   32'(dif.bus_addr),   32'd0);
        chk("rst_bus_rd_en",  32'(dif.bus_rd_en),  32'd0);
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        chk("rst_src_read", 32'(dif.cpu_rdata), 32'hFF);

        // Idle passthrough
        drive(1'b0, 1'b1, 16'hC000, 8'h5A);
        chk("pt_wr_en",  32'(dif.bus_wr_en), 32'd1);
        chk("pt_wr_adr", 32'(dif.bus_addr),  32'hC000);
        chk("pt_wdata",  32'(dif.bus_wdata), 32'h5A);
        drive(1'b1, 1'b0, 16'hC05A, 8'h00);
        chk("pt_rd_en",  32'(dif.bus_rd_en), 32'd1);
        chk("pt_rdata",  32'(dif.cpu_rdata), 32'h5A);
        drive(1'b1, 1'b1, 16'hC010, 8'h44);
        chk("rw_wr_en",  32'(dif.bus_wr_en), 32'd1);
        chk("rw_rd_en",  32'(dif.bus_rd_en), 32'd0);

        // Full transfer from 0xC100
        we0 = we_cnt; a0 = act_cnt;
        drive(1'b0, 1'b1, 16'hFF46, 8'hC1);
        chk("ft_wr_cycle_active", 32'(dif.dma_active), 32'd0);
        chk("ft_wr_not_fwd",      32'(dif.bus_wr_en),  32'd0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("ft_delay_active", 32'(dif.dma_active), 32'd1);
        chk("ft_delay_we",     32'(dif.oam_we),     32'd0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("ft_first_we",   32'(dif.oam_we),   32'd1);
        chk("ft_first_addr", 32'(dif.bus_addr), 32'hC100);
        chk("ft_first_idx",  32'(dif.oam_addr), 32'd0);
        run_until_idle(400);
        chk("ft_we_count",  32'(we_cnt - we0),  32'd160);
        chk("ft_act_count", 32'(act_cnt - a0),  32'd161);
        chk("ft_last_addr", 32'(last_dma),      32'hC19F);
        bad = 0;
        for (int i = 0; i < OAM_LEN; i++) if (oam_mem[i] !== 8'(i)) bad++;
        chk("ft_oam_bad_bytes", 32'(bad), 32'd0);
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        chk("ft_src_read", 32'(dif.cpu_rdata), 32'hC1);

        // Lockout and HRAM yields
        we0 = we_cnt; a0 = act_cnt;
        drive(1'b0, 1'b1, 16'hFF46, 8'hC1);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1'b0, 1'b1, 16'hC000, 8'h33);
        chk("lk_wr_dropped", 32'(dif.bus_wr_en), 32'd0);
        chk("lk_copy_we",    32'(dif.oam_we),    32'd1);
        drive(1'b1, 1'b0, 16'h8000, 8'h00);
        chk("lk_rd_8000", 32'(dif.cpu_rdata), 32'(LOCK_RD));
        drive(1'b1, 1'b0, 16'hFF90, 8'h00);
        chk("hr_rd_addr",  32'(dif.bus_addr),  32'hFF90);
        chk("hr_rd_data",  32'(dif.cpu_rdata), 32'h90);
        chk("hr_rd_yield", 32'(dif.oam_we),    32'd0);
        chk("hr_rd_idx",   32'(dif.oam_addr),  32'd2);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("hr_idx_held", 32'(dif.oam_addr), 32'd2);
        drive(1'b0, 1'b1, 16'hFF91, 8'h77);
        chk("hr_wr_en",    32'(dif.bus_wr_en), 32'd1);
        chk("hr_wdata",    32'(dif.bus_wdata), 32'h77);
        chk("hr_wr_yield", 32'(dif.oam_we),    32'd0);
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        chk("lk_src_read", 32'(dif.cpu_rdata), 32'hC1);
        chk("lk_idx_held", 32'(dif.oam_addr),  32'd3);
        run_until_idle(400);
        chk("lk_we_count",  32'(we_cnt - we0), 32'd160);
        chk("lk_act_count", 32'(act_cnt - a0), 32'd163);

        // Restart mid-copy
        we0 = we_cnt; a0 = act_cnt;
        drive(1'b0, 1'b1, 16'hFF46, 8'hC1);
        run_to_idx(49, "rs_reach_49");
        drive(1'b0, 1'b1, 16'hFF46, 8'hD0);
        chk("rs_wr_idx",  32'(dif.oam_addr), 32'd50);
        chk("rs_wr_addr", 32'(dif.bus_addr), 32'hC132);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("rs_delay_active", 32'(dif.dma_active), 32'd1);
        chk("rs_delay_we",     32'(dif.oam_we),     32'd0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("rs_new_addr", 32'(dif.bus_addr), 32'hD000);
        chk("rs_new_idx",  32'(dif.oam_addr), 32'd0);
        run_until_idle(400);
        chk("rs_we_count",  32'(we_cnt - we0), 32'd211);
        chk("rs_act_count", 32'(act_cnt - a0), 32'd213);
        chk("rs_last_addr", 32'(last_dma),     32'hD09F);

        // Echo-RAM source
        drive(1'b0, 1'b1, 16'hFF46, 8'hE2);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("ec_first_addr", 32'(dif.bus_addr), 32'hC200);
        run_until_idle(400);
        chk("ec_last_addr", 32'(last_dma), 32'hC29F);

        // Reset mid-transfer
        drive(1'b0, 1'b1, 16'hFF46, 8'hC1);
        run_to_idx(79, "rm_reach_79");
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("rm_rst_cycle_idx", 32'(dif.oam_addr), 32'd80);
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        chk("rm_active",   32'(dif.dma_active), 32'd0);
        chk("rm_oam_we",   32'(dif.oam_we),     32'd0);
        chk("rm_oam_addr", 32'(dif.oam_addr),   32'd0);
        chk("rm_src_read", 32'(dif.cpu_rdata),  32'hFF);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1'b0, 1'b0, 16'h0000, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
# oam_dma

Bus stage directly downstream of the CPU core. It takes the CPU's `rd_en`/`wr_en`/`addr_out`/`data_out` strobes and forwards them to the system memory bus, returning read data to the CPU `data_in` port. It also owns the DMA source register at 0xFF46. A write to that register starts a 160-byte copy from `{src,8'h00}` into OAM; while the copy runs, the CPU is locked out of every address except HRAM.

## Interface
- `OAM_LEN`, default 160: bytes per transfer; index range 0..OAM_LEN-1.
- `START_DELAY`, default 1: idle cycles between the 0xFF46 write and the first copy.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cpu_rd_en`  in  1  CPU read strobe.
- `cpu_wr_en`  in  1  CPU write strobe.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  read data to CPU `data_in`; combinational.
- `bus_rd_en`  out  1  system bus read strobe.
- `bus_wr_en`  out  1  system bus write strobe.
- `bus_addr`  out  16  system bus address.
- `bus_wdata`  out  8  system bus write data.
- `bus_rdata`  in  8  system bus read data; valid in the same cycle as `bus_rd_en`.
- `oam_we`  out  1  OAM write enable.
- `oam_addr`  out  8  OAM byte index.
- `oam_wdata`  out  8  OAM write data.
- `dma_active`  out  1  high from the cycle after the accepted 0xFF46 write until the last byte is written.

## Operation
- States: IDLE, DELAY, ACTIVE.
- Registers:
  - `src_reg`: reset 8'hFF.
  - `idx`: 8 bits.
  - `dly`: counter sized to hold START_DELAY.
- Register 0xFF46 is local:
  - CPU write: loads `src_reg` and is never forwarded to the bus.
  - CPU read: returns `src_reg`.
  - Both work in every state.
- Write to 0xFF46 in any state:
  - Go to DELAY with `dly` = START_DELAY-1 and `idx` = 0.
  - A write during ACTIVE restarts the copy from index 0 with the new source.
  - `dma_active` stays high through the restart.
- DELAY:
  - Decrement `dly`; on zero go to ACTIVE.
  - The CPU is already locked out.
- ACTIVE, per copy cycle:
  - Drive `bus_rd_en`=1 and `bus_addr` = `{eff_src, idx}`.
  - Drive `oam_we`=1, `oam_addr`=`idx`, `oam_wdata`=`bus_rdata`.
  - Then `idx`++.
  - When `idx` = OAM_LEN-1 is written, go to IDLE.
- Source mapping: `eff_src` = `src_reg` when `src_reg` < 0xE0, otherwise `src_reg` & 8'hDF (echo-RAM mirror).
- HRAM (0xFF80–0xFFFE) during DELAY/ACTIVE:
  - CPU accesses are forwarded to the bus.
  - In ACTIVE the DMA yields that cycle: no bus read, `oam_we`=0, `idx` holds.
- Other CPU accesses during DELAY/ACTIVE:
  - Writes are dropped.
  - Reads return 8'hFF.
- IDLE: every CPU access except 0xFF46 passes through unchanged; `oam_we`=0.
- `bus_wr_en` is asserted only for forwarded CPU writes. DMA never writes the bus.
- Simultaneous `cpu_rd_en` and `cpu_wr_en`: the write wins and the read is ignored.

## Timing
- Reset values:
  - state IDLE, `src_reg` 8'hFF, `idx` 0.
  - `dma_active` 0, `oam_we` 0, `oam_addr` 0, `oam_wdata` 0.
  - Bus strobes 0, `bus_addr` 0.
- Write to 0xFF46 at edge N:
  - `dma_active`=1 from cycle N+1.
  - First `oam_we` at cycle N+1+START_DELAY.
- Copy rate and completion:
  - One byte per cycle when there are no HRAM yields.
  - Last `oam_we` at cycle N+START_DELAY+OAM_LEN.
  - `dma_active` falls at the next edge.
- Each HRAM yield extends completion by exactly 1 cycle.
- `rst` mid-transfer: state returns to IDLE next edge with all outputs at reset values; OAM is left partially written.
- Data paths are combinational:
  - `cpu_rdata` from `bus_rdata`.
  - `bus_*` from `cpu_*` in IDLE.

## Configuration
- `OAM_DMA_BUS_CONFLICT_EN`:
  - Defined: during ACTIVE, a CPU read outside HRAM and 0xFF46 returns the byte DMA is reading this cycle (`bus_rdata`), modelling bus conflict.
  - Defined, DELAY state: such reads still return 8'hFF.
  - Undefined: such reads return 8'hFF in both DELAY and ACTIVE.

## Test plan
- Idle passthrough:
  - CPU write 0x5A to 0xC000 -> `bus_wr_en`=1, `bus_addr`=0xC000, `bus_wdata`=0x5A.
  - CPU read 0xC000 -> `cpu_rdata`=`bus_rdata`.
- Full transfer:
  - Write 0xC1 to 0xFF46 with memory byte = low address byte.
  - -> 160 `oam_we` pulses; OAM[i]=i; `bus_addr` runs 0xC100..0xC19F.
  - -> `dma_active` high for exactly 161 cycles.
  - -> read 0xFF46 returns 0xC1.
- Lockout:
  - During ACTIVE, CPU write to 0xC000 -> no `bus_wr_en`.
  - CPU read 0x8000 -> 0xFF, or `bus_rdata` with the macro defined.
  - CPU read/write 0xFF90 -> forwarded, and `idx` holds that cycle.
- Restart:
  - Write 0xD0 to 0xFF46 at `idx`=50.
  - -> after START_DELAY, copy resumes at `bus_addr` 0xD000 with `oam_addr`=0.
  - -> `dma_active` never drops.
- Echo source: write 0xE2 -> reads from 0xC200..0xC29F.
- Reset mid-transfer: assert `rst` at `idx`=80 -> next cycle `dma_active`=0, `oam_we`=0, 0xFF46 reads 0xFF.
